// File: rtl/wb_pkg.sv
// Shared Wishbone widths, request bundle, responder FSM states and the
// byte-lane merge used by wb_reg_slave.
package wb_pkg;
    localparam int WB_ADDR_W = 30;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } resp_state_t;

    function automatic logic [WB_DATA_W-1:0] merge_bytes(
        input logic [WB_DATA_W-1:0] old_val,
        input logic [WB_DATA_W-1:0] new_val,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] r;
        r = old_val;
        for (int n = 0; n < WB_SEL_W; n++) begin
            if (sel[n]) r[8*n +: 8] = new_val[8*n +: 8];
        end
        return r;
    endfunction
endpackage

// File: rtl/wb_resp_delay.sv
// Response timing for wb_reg_slave: wait-state counter, ack/err pulse generation
// and abort of a pending response when the bus cycle is dropped.
module wb_resp_delay
    import wb_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cyc,
    input  logic        i_accept,
    input  logic        i_err,
    output logic        o_stall,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_load,
    output resp_state_t o_state
);
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    resp_state_t state;
    logic [2:0]  cnt;
    logic        resp_err;

    assign o_state = state;

    // High on the edge that raises o_ack, so read data lands in the same cycle.
    assign o_load = i_cyc &&
                    (((state == IDLE) && i_accept && (WAIT_STATES == 0) && !i_err) ||
                     ((state == WAIT) && (cnt == 3'd1) && !resp_err));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            resp_err <= 1'b0;
            o_stall  <= 1'b0;
            o_ack    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_ack <= 1'b0;
            o_err <= 1'b0;
            if (!i_cyc) begin
                state   <= IDLE;
                o_stall <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_accept) begin
                            if (WAIT_STATES == 0) begin
                                o_ack <= !i_err;
                                o_err <= i_err;
                            end else begin
                                state    <= WAIT;
                                cnt      <= WS_LOAD;
                                resp_err <= i_err;
                                o_stall  <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state <= ACK;
                            o_ack <= !resp_err;
                            o_err <= resp_err;
                        end
                    end
                    ACK: begin
                        state   <= IDLE;
                        o_stall <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        o_stall <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/wb_reg_slave.sv
// Pipelined Wishbone B4 register-file responder; reg0[7:0] drives the LEDs.
// Define WB_REG_SLAVE_ERR_EN to answer out-of-range accesses with o_wb_err.
module wb_reg_slave
    import wb_pkg::*;
#(
    parameter int          NREGS       = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5742_0001
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [31:0] o_wb_data,
    output logic [7:0]  o_leds
);
    localparam int               IDX_W = $clog2(NREGS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NREGS - 1);

    logic [WB_DATA_W-1:0] regs [NREGS];
    wb_req_t              req;
    logic [IDX_W-1:0]     idx;
    logic                 accept;
    logic                 in_range;
    logic                 err_cond;
    logic                 load;
    logic                 pend_rd;
    logic                 fire_rd;
    logic [WB_DATA_W-1:0] rd_now;
    logic [WB_DATA_W-1:0] pend_data;
    logic [WB_DATA_W-1:0] fire_data;
    resp_state_t          resp_state;

    assign req      = '{we: i_wb_we, addr: i_wb_addr, data: i_wb_data, sel: i_wb_sel};
    assign accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign idx      = req.addr[IDX_W-1:0];
    assign in_range = ~|req.addr[WB_ADDR_W-1:IDX_W];

`ifdef WB_REG_SLAVE_ERR_EN
    assign err_cond = ~in_range;
`else
    assign err_cond = 1'b0;
`endif

    always_comb begin
        rd_now = '0;
        if (in_range) rd_now = (idx == LAST) ? ID_VALUE : regs[idx];
    end

    // A zero-wait ack fires on the accept edge itself; otherwise use the captured read.
    assign fire_rd   = load & ((resp_state == IDLE) ? ~req.we : pend_rd);
    assign fire_data = (resp_state == IDLE) ? rd_now : pend_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pend_rd   <= 1'b0;
            pend_data <= '0;
            o_wb_data <= '0;
        end else begin
            if (accept) begin
                pend_rd   <= ~req.we;
                pend_data <= rd_now;
            end
            if (accept && req.we && in_range && (idx != LAST)) begin
                regs[idx] <= merge_bytes(regs[idx], req.data, req.sel);
            end
            if (fire_rd) o_wb_data <= fire_data;
        end
    end

    assign o_leds = regs[0][7:0];

    wb_resp_delay #(
        .WAIT_STATES(WAIT_STATES)
    ) u_resp (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_cyc   (i_wb_cyc),
        .i_accept(accept),
        .i_err   (err_cond),
        .o_stall (o_wb_stall),
        .o_ack   (o_wb_ack),
        .o_err   (o_wb_err),
        .o_load  (load),
        .o_state (resp_state)
    );
endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: one zero-wait instance (u=0) and one three-wait instance (u=1)
// checked against an array model of the register file.
module tb_wb_reg_slave;
    localparam logic [31:0] ID = 32'h5742_0001;
`ifdef WB_REG_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  cyc, stb, we, stall, ack, err;
    logic [29:0] addr [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] rdat [2];
    logic [7:0]  leds [2];

    logic [31:0] model   [2][16];
    logic [31:0] last_rd [2];
    int          lat_exp [2];
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    wb_reg_slave #(.NREGS(16), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
        .i_wb_addr(addr[0]), .i_wb_data(wdat[0]), .i_wb_sel(sel[0]), .o_wb_stall(stall[0]),
        .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_data(rdat[0]), .o_leds(leds[0]));

    wb_reg_slave #(.NREGS(16), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
        .i_wb_addr(addr[1]), .i_wb_data(wdat[1]), .i_wb_sel(sel[1]), .o_wb_stall(stall[1]),
        .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_data(rdat[1]), .o_leds(leds[1]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic void clear_model();
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 16; a++) model[u][a] = 32'h0;
            last_rd[u] = 32'h0;
        end
    endfunction

    function automatic void ref_write(input int u, input int a, input logic [31:0] d, input logic [3:0] s);
        if (a < 15) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[u][a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        // caller handles the 'a' out-of-range case
        return 32'h0;
    endfunction

    // driver
    task automatic xfer(input int u, input logic w, input logic [29:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic g_ack, output logic g_err,
                        output logic [31:0] g_data, output int g_lat, output logic g_both);
        g_ack = 1'b0; g_err = 1'b0; g_both = 1'b0; g_data = '0; g_lat = 0;
        @(posedge clk); #1;
        cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; addr[u] = a; wdat[u] = d; sel[u] = s;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            stb[u] = 1'b0;
            if (ack[u] || err[u]) begin
                g_ack = ack[u]; g_err = err[u]; g_both = ack[u] & err[u];
                g_data = rdat[u]; g_lat = k;
                break;
            end
        end
        cyc[u] = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({stall[u], ack[u], err[u]} !== 3'b000) begin
                n_fail++; $display("FAIL reset_ctl u=%0d: got %b want 000", u, {stall[u], ack[u], err[u]});
            end
            n_checks++;
            if (rdat[u] !== 32'h0) begin
                n_fail++; $display("FAIL reset_data u=%0d: got %h want 0", u, rdat[u]);
            end
            n_checks++;
            if (leds[u] !== 8'h0) begin
                n_fail++; $display("FAIL reset_leds u=%0d: got %h want 0", u, leds[u]);
            end
        end
    endtask

    task automatic test_leds();
        logic ga, ge, gb; logic [31:0] gd; int gl;
        xfer(0, 1'b1, 30'd0, 32'h0000_00A5, 4'hF, ga, ge, gd, gl, gb);
        ref_write(0, 0, 32'h0000_00A5, 4'hF);
        n_checks++;
        if (ga !== 1'b1 || gl != 1) begin
            n_fail++; $display("FAIL leds_ack: got ack=%b lat=%0d want ack=1 lat=1", ga, gl);
        end
        n_checks++;
        if (leds[0] !== model[0][0][7:0]) begin
            n_fail++; $display("FAIL leds_value: got %h want %h", leds[0], model[0][0][7:0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic ga, ge, gb; logic [31:0] gd; int gl;
        xfer(0, 1'b1, 30'd2, 32'h1122_3344, 4'hF, ga, ge, gd, gl, gb);
        ref_write(0, 2, 32'h1122_3344, 4'hF);
        xfer(0, 1'b1, 30'd2, 32'hFFFF_FFFF, 4'b0101, ga, ge, gd, gl, gb);
        ref_write(0, 2, 32'hFFFF_FFFF, 4'b0101);
        xfer(0, 1'b1, 30'd2, 32'h0BAD_0BAD, 4'h0, ga, ge, gd, gl, gb);
        n_checks++;
        if (ga !== 1'b1) begin
            n_fail++; $display("FAIL sel0_ack: got %b want 1", ga);
        end
        xfer(0, 1'b0, 30'd2, 32'h0, 4'hF, ga, ge, gd, gl, gb);
        n_checks++;
        if (ga !== 1'b1 || gd !== model[0][2]) begin
            n_fail++; $display("FAIL byte_lanes: got ack=%b data=%h want ack=1 data=%h", ga, gd, model[0][2]);
        end
        last_rd[0] = model[0][2];
        xfer(0, 1'b1, 30'd5, 32'hCAFE_F00D, 4'hF, ga, ge, gd, gl, gb);
        ref_write(0, 5, 32'hCAFE_F00D, 4'hF);
        n_checks++;
        if (rdat[0] !== last_rd[0]) begin
            n_fail++; $display("FAIL data_hold: got %h want %h", rdat[0], last_rd[0]);
        end
    endtask

    task automatic test_id();
        logic ga, ge, gb; logic [31:0] gd; int gl;
        for (int u = 0; u < 2; u++) begin
            xfer(u, 1'b1, 30'd15, 32'h0, 4'hF, ga, ge, gd, gl, gb);
            xfer(u, 1'b0, 30'd15, 32'h0, 4'hF, ga, ge, gd, gl, gb);
            n_checks++;
            if (ga !== 1'b1 || gd !== ID || gl != lat_exp[u]) begin
                n_fail++; $display("FAIL id_read u=%0d: got ack=%b data=%h lat=%0d want ack=1 data=%h lat=%0d",
                                   u, ga, gd, gl, ID, lat_exp[u]);
            end
            last_rd[u] = ID;
        end
    endtask

    task automatic test_random();
        logic ga, ge, gb, w, oor, e_ack, e_err; logic [31:0] gd, d, e_d; int gl, u, a; logic [3:0] s;
        for (int i = 0; i < 40; i++) begin
            u = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 1023) : $urandom_range(0, 15);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            xfer(u, w, 30'(a), d, s, ga, ge, gd, gl, gb);
            oor   = (a >= 16);
            e_err = oor & ERR_EN;
            e_ack = ~e_err;
            if (!w && !e_err) e_d = oor ? 32'h0 : ((a == 15) ? ID : model[u][a]);
            else              e_d = last_rd[u];
            n_checks++;
            if (ga !== e_ack || ge !== e_err || gb !== 1'b0 || gl != lat_exp[u]) begin
                n_fail++; $display("FAIL rand_resp i=%0d u=%0d a=%0d: got ack=%b err=%b lat=%0d want ack=%b err=%b lat=%0d",
                                   i, u, a, ga, ge, gl, e_ack, e_err, lat_exp[u]);
            end
            n_checks++;
            if (gd !== e_d) begin
                n_fail++; $display("FAIL rand_data i=%0d u=%0d a=%0d we=%b: got %h want %h", i, u, a, w, gd, e_d);
            end
            if (w && !oor) ref_write(u, a, d, s);
            last_rd[u] = e_d;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ack_pat;
        logic        stall_seen;
        logic [31:0] e_d;
        ack_pat = '0; stall_seen = 1'b0;
        for (int a = 0; a < 4; a++) exp_q.push_back(model[0][a]);
        @(posedge clk); #1;
        cyc[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin stb[0] = 1'b1; addr[0] = 30'(k); end
            else stb[0] = 1'b0;
            @(posedge clk); #1;
            stall_seen |= stall[0];
            ack_pat[k] = ack[0];
            if (ack[0]) begin
                e_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
                n_checks++;
                if (rdat[0] !== e_d) begin
                    n_fail++; $display("FAIL b2b_data k=%0d: got %h want %h", k, rdat[0], e_d);
                end
                last_rd[0] = e_d;
            end
        end
        cyc[0] = 1'b0;
        exp_q.delete();
        n_checks++;
        if (ack_pat !== 8'b0000_1111 || stall_seen !== 1'b0) begin
            n_fail++; $display("FAIL b2b_acks: got pattern=%b stall=%b want pattern=00001111 stall=0", ack_pat, stall_seen);
        end
    endtask

    task automatic test_wait_states();
        int stall_cnt, ack_at, ack_cnt; logic [31:0] gd;
        stall_cnt = 0; ack_at = 0; ack_cnt = 0; gd = '0;
        @(posedge clk); #1;
        n_checks++;
        if (stall[1] !== 1'b0) begin
            n_fail++; $display("FAIL ws_idle_stall: got %b want 0", stall[1]);
        end
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 30'd2; sel[1] = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            stb[1] = 1'b0;
            if (stall[1]) stall_cnt++;
            if (ack[1]) begin ack_cnt++; ack_at = k; gd = rdat[1]; end
        end
        cyc[1] = 1'b0;
        n_checks++;
        if (stall_cnt != 4 || ack_at != 4 || ack_cnt != 1) begin
            n_fail++; $display("FAIL ws_timing: got stall=%0d ack_at=%0d acks=%0d want stall=4 ack_at=4 acks=1",
                               stall_cnt, ack_at, ack_cnt);
        end
        n_checks++;
        if (gd !== model[1][2]) begin
            n_fail++; $display("FAIL ws_data: got %h want %h", gd, model[1][2]);
        end
        last_rd[1] = model[1][2];
    endtask

    task automatic test_cyc_abort();
        logic ga, ge, gb; logic [31:0] gd, d; int gl, resp;
        d = $urandom | 32'h0100_0000;
        resp = 0;
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 30'd1; wdat[1] = d; sel[1] = 4'hF;
        @(posedge clk); #1;
        stb[1] = 1'b0; cyc[1] = 1'b0;
        ref_write(1, 1, d, 4'hF);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) cyc[1] = 1'b1;
            if (ack[1] || err[1]) resp++;
        end
        cyc[1] = 1'b0;
        n_checks++;
        if (resp != 0 || stall[1] !== 1'b0) begin
            n_fail++; $display("FAIL abort_resp: got responses=%0d stall=%b want 0 0", resp, stall[1]);
        end
        xfer(1, 1'b0, 30'd1, 32'h0, 4'hF, ga, ge, gd, gl, gb);
        n_checks++;
        if (ga !== 1'b1 || gd !== model[1][1]) begin
            n_fail++; $display("FAIL abort_write_kept: got ack=%b data=%h want ack=1 data=%h", ga, gd, model[1][1]);
        end
        last_rd[1] = model[1][1];
    endtask

    task automatic test_out_of_range();
        logic ga, ge, gb; logic [31:0] gd, d, e_d; int gl;
        for (int u = 0; u < 2; u++) begin
            d = $urandom | 32'h8000_0000;
            xfer(u, 1'b1, 30'd4, d, 4'hF, ga, ge, gd, gl, gb);
            ref_write(u, 4, d, 4'hF);
            xfer(u, 1'b0, 30'd4, 32'h0, 4'hF, ga, ge, gd, gl, gb);
            last_rd[u] = model[u][4];
            xfer(u, 1'b1, 30'h100, 32'h0000_00C3, 4'hF, ga, ge, gd, gl, gb);
            n_checks++;
            if (leds[u] !== model[u][0][7:0] || ga !== ~ERR_EN || ge !== ERR_EN) begin
                n_fail++; $display("FAIL oor_write u=%0d: got leds=%h ack=%b err=%b want leds=%h ack=%b err=%b",
                                   u, leds[u], ga, ge, model[u][0][7:0], ~ERR_EN, ERR_EN);
            end
            xfer(u, 1'b0, 30'h100, 32'h0, 4'hF, ga, ge, gd, gl, gb);
            e_d = ERR_EN ? last_rd[u] : 32'h0;
            n_checks++;
            if (ga !== ~ERR_EN || ge !== ERR_EN || gd !== e_d || gl != lat_exp[u]) begin
                n_fail++; $display("FAIL oor_read u=%0d: got ack=%b err=%b data=%h lat=%0d want ack=%b err=%b data=%h lat=%0d",
                                   u, ga, ge, gd, gl, ~ERR_EN, ERR_EN, e_d, lat_exp[u]);
            end
            last_rd[u] = e_d;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic ga, ge, gb; logic [31:0] gd; int gl, resp;
        resp = 0;
        xfer(1, 1'b1, 30'd0, 32'h0000_005A, 4'h1, ga, ge, gd, gl, gb);
        ref_write(1, 0, 32'h0000_005A, 4'h1);
        n_checks++;
        if (leds[1] !== model[1][0][7:0]) begin
            n_fail++; $display("FAIL pre_reset_leds: got %h want %h", leds[1], model[1][0][7:0]);
        end
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 30'd0; sel[1] = 4'hF;
        @(posedge clk); #1;
        stb[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) resp++;
        end
        cyc[1] = 1'b0;
        n_checks++;
        if (resp != 0 || leds[1] !== model[1][0][7:0] || rdat[1] !== 32'h0 || leds[0] !== model[0][0][7:0]) begin
            n_fail++; $display("FAIL reset_mid_wait: got resp=%0d leds1=%h data1=%h leds0=%h want 0 %h 0 %h",
                               resp, leds[1], rdat[1], leds[0], model[1][0][7:0], model[0][0][7:0]);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        lat_exp[0] = 1; lat_exp[1] = 4;
        cyc = '0; stb = '0; we = '0;
        for (int u = 0; u < 2; u++) begin addr[u] = '0; wdat[u] = '0; sel[u] = '0; end
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_leds();
        test_byte_lanes();
        test_id();
        test_random();
        test_back_to_back();
        test_wait_states();
        test_cyc_abort();
        test_out_of_range();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
